// File: rtl/fangwei_pkg.sv
// ----------------------------------------------------------------------------
// fangwei_pkg
// Shared definitions for the fangwei beamformer accumulator slice:
//   - default widths/channel count used as parameter defaults by the top
//   - channel index width (fixed at 7 bits, channels 1..127 addressable)
//   - FSM state enumeration of the frame accumulator
// No ports (package).
// ----------------------------------------------------------------------------
package fangwei_pkg;

    localparam int DEF_NUM_CH = 48;
    localparam int DEF_DW     = 16;
    localparam int DEF_ACC_W  = 40;
    localparam int IDX_W      = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } beam_state_t;

endpackage

// File: rtl/fangwei_cmult.sv
// ----------------------------------------------------------------------------
// fangwei_cmult
// Registered complex multiplier, latency 1:
//   p = (a_re*b_re - a_im*b_im) + j(a_re*b_im + a_im*b_re)
// kept at full 2*DW+1 bit signed precision (the extra bit covers the
// -1 * -1 + -1 * -1 corner of Q1.15 operands).
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   a_re, a_im         first operand (sample), signed DW
//   b_re, b_im         second operand (coefficient), signed DW
//   p_re, p_im         registered product, signed 2*DW+1
// ----------------------------------------------------------------------------
module fangwei_cmult #(
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [DW-1:0]  a_re,
    input  logic signed [DW-1:0]  a_im,
    input  logic signed [DW-1:0]  b_re,
    input  logic signed [DW-1:0]  b_im,
    output logic signed [2*DW:0]  p_re,
    output logic signed [2*DW:0]  p_im
);

    logic signed [2*DW-1:0] rr;
    logic signed [2*DW-1:0] ii;
    logic signed [2*DW-1:0] ri;
    logic signed [2*DW-1:0] ir;
    logic signed [2*DW:0]   re_c;
    logic signed [2*DW:0]   im_c;

    assign rr = a_re * b_re;
    assign ii = a_im * b_im;
    assign ri = a_re * b_im;
    assign ir = a_im * b_re;

    // Sign-extend each partial product by one bit before combining so the
    // sum/difference cannot overflow.
    assign re_c = {rr[2*DW-1], rr} - {ii[2*DW-1], ii};
    assign im_c = {ri[2*DW-1], ri} + {ir[2*DW-1], ir};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_re <= '0;
            p_im <= '0;
        end else begin
            p_re <= re_c;
            p_im <= im_c;
        end
    end

endmodule

// File: rtl/fangwei_beam_accum.sv
// ----------------------------------------------------------------------------
// fangwei_beam_accum
// Sums the complex products sample*coefficient over the NUM_CH channels of
// one azimuth frame and emits the beam once per complete frame.
//
// Pipeline:  cycle T   sample on ch_*, c = ch_idx drives the coefficient ROM
//            S1 (T+1)  sample registered, coefficient arrives from the ROM
//            S2 (T+2)  complex product registered (fangwei_cmult)
//            S3        product accumulated, sequence checked, FSM updated
//            beam_valid / frame_err are visible at T+3.
//
// Handshake: ch_valid qualifies ch_idx/ch_real/ch_image in the cycle it is
// high; there is no backpressure, every valid sample is consumed. beam_valid
// and frame_err are single-cycle pulses with no ready.
//
// Build option: FANGWEI_BEAM_SAT_EN -- when defined the accumulator clamps to
// the signed ACC_W range instead of wrapping.
//
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   ch_valid                channel sample present
//   ch_idx [6:0]            channel number, 1..NUM_CH, strictly sequential
//   ch_real, ch_image       channel sample, signed Q1.15
//   c [6:0]                 coefficient selector (= ch_idx, combinational)
//   coef_real, coef_image   coefficient, valid one cycle after c
//   beam_real, beam_image   beam sum, held until the next completed frame
//   beam_valid              one-cycle pulse qualifying the beam
//   frame_err               one-cycle pulse on an index sequence violation
// ----------------------------------------------------------------------------
module fangwei_beam_accum
    import fangwei_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DW     = DEF_DW,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ch_valid,
    input  logic [IDX_W-1:0]        ch_idx,
    input  logic signed [DW-1:0]    ch_real,
    input  logic signed [DW-1:0]    ch_image,
    output logic [IDX_W-1:0]        c,
    input  logic signed [DW-1:0]    coef_real,
    input  logic signed [DW-1:0]    coef_image,
    output logic signed [ACC_W-1:0] beam_real,
    output logic signed [ACC_W-1:0] beam_image,
    output logic                    beam_valid,
    output logic                    frame_err
);

    localparam int               PW       = 2*DW + 1;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH);

    // Adds two accumulator-width values; wraps or clamps depending on build.
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
`ifdef FANGWEI_BEAM_SAT_EN
        // Overflow when the two top bits of the widened sum disagree.
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
        return s[ACC_W-1:0];
    endfunction

    // ---------------- S1: align the sample with the coefficient -------------
    logic                  s1_valid;
    logic [IDX_W-1:0]      s1_idx;
    logic signed [DW-1:0]  s1_re;
    logic signed [DW-1:0]  s1_im;

    assign c = ch_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else begin
            s1_valid <= ch_valid;
            s1_idx   <= ch_idx;
            s1_re    <= ch_real;
            s1_im    <= ch_image;
        end
    end

    // ---------------- S2: complex product ------------------------------------
    logic signed [PW-1:0]  p_re;
    logic signed [PW-1:0]  p_im;
    logic                  s2_valid;
    logic [IDX_W-1:0]      s2_idx;

    fangwei_cmult #(.DW(DW)) u_cmult (
        .clk  (clk),
        .rst  (rst),
        .a_re (s1_re),
        .a_im (s1_im),
        .b_re (coef_real),
        .b_im (coef_image),
        .p_re (p_re),
        .p_im (p_im)
    );

    // Control travels beside the multiplier so it lines up with its output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_idx   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
        end
    end

    // ---------------- S3: accumulate and sequence check ----------------------
    beam_state_t       state;
    logic [IDX_W-1:0]  exp_idx;   // next index expected while in ST_ACCUM
    logic [ACC_W-1:0]  acc_re;
    logic [ACC_W-1:0]  acc_im;

    logic [ACC_W-1:0]  p_re_ext;
    logic [ACC_W-1:0]  p_im_ext;
    logic [ACC_W-1:0]  acc_re_n;
    logic [ACC_W-1:0]  acc_im_n;
    logic              take;      // sample belongs to a frame (start or next)
    logic              bad;       // sequence violation this cycle
    logic              last;      // sample closes the frame

    assign p_re_ext = ACC_W'(p_re);
    assign p_im_ext = ACC_W'(p_im);

    always_comb begin
        acc_re_n = acc_re;
        acc_im_n = acc_im;
        take     = 1'b0;
        bad      = 1'b0;
        if (s2_valid) begin
            if (s2_idx == IDX_ONE) begin
                // Index 1 always starts a fresh frame; mid-frame it also
                // flags the abandoned one.
                take     = 1'b1;
                bad      = (state == ST_ACCUM);
                acc_re_n = p_re_ext;
                acc_im_n = p_im_ext;
            end else if (state == ST_ACCUM && s2_idx == exp_idx) begin
                take     = 1'b1;
                acc_re_n = acc_add(acc_re, p_re_ext);
                acc_im_n = acc_add(acc_im, p_im_ext);
            end else begin
                // idx 0, idx > NUM_CH, skipped/repeated idx, or a non-1
                // index outside a frame.
                bad = 1'b1;
            end
        end
        last = take && (s2_idx == LAST_IDX);
    end

    // Single FSM block; DONE lasts one cycle but still accepts an idx 1 so the
    // next frame can follow without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            exp_idx    <= '0;
            acc_re     <= '0;
            acc_im     <= '0;
            beam_real  <= '0;
            beam_image <= '0;
            beam_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            beam_valid <= last;
            frame_err  <= bad;
            if (last) begin
                state      <= ST_DONE;
                beam_real  <= acc_re_n;
                beam_image <= acc_im_n;
                acc_re     <= '0;
                acc_im     <= '0;
            end else if (take) begin
                state   <= ST_ACCUM;
                exp_idx <= s2_idx + IDX_W'(1);
                acc_re  <= acc_re_n;
                acc_im  <= acc_im_n;
            end else if (bad) begin
                state  <= ST_IDLE;
                acc_re <= '0;
                acc_im <= '0;
            end else if (state == ST_DONE) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fangwei_beam_accum.sv
module tb_fangwei_beam_accum;

  localparam int NUM_CH  = 48;
  localparam int DW      = 16;
  localparam int ACC_W   = 40;
  localparam int ACC_W_S = 34;

`ifdef FANGWEI_BEAM_SAT_EN
  localparam logic [ACC_W_S-1:0] EXP_S_MAX = 34'h1FFFFFFFF;
`else
  localparam logic [ACC_W_S-1:0] EXP_S_MAX = 34'h3FFD00030;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic              ch_valid;
  logic [6:0]        ch_idx;
  logic [DW-1:0]     ch_real, ch_image;
  logic [6:0]        c, c_s;
  logic [DW-1:0]     coef_real, coef_image;
  logic [ACC_W-1:0]  beam_real, beam_image;
  logic              beam_valid, frame_err;
  logic [ACC_W_S-1:0] beam_real_s, beam_image_s;
  logic              beam_valid_s, frame_err_s;

  fangwei_beam_accum #(.NUM_CH(NUM_CH), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_idx(ch_idx),
    .ch_real(ch_real), .ch_image(ch_image), .c(c),
    .coef_real(coef_real), .coef_image(coef_image),
    .beam_real(beam_real), .beam_image(beam_image),
    .beam_valid(beam_valid), .frame_err(frame_err)
  );

  // Narrow-accumulator instance sharing the same stimulus.
  fangwei_beam_accum #(.NUM_CH(NUM_CH), .DW(DW), .ACC_W(ACC_W_S)) dut_s (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_idx(ch_idx),
    .ch_real(ch_real), .ch_image(ch_image), .c(c_s),
    .coef_real(coef_real), .coef_image(coef_image),
    .beam_real(beam_real_s), .beam_image(beam_image_s),
    .beam_valid(beam_valid_s), .frame_err(frame_err_s)
  );

  // Coefficient ROM model: one-cycle read latency from c.
  logic [DW-1:0] cr_tbl [0:127];
  logic [DW-1:0] ci_tbl [0:127];
  always @(posedge clk) begin
    coef_real  <= cr_tbl[c];
    coef_image <= ci_tbl[c];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int               due;
    logic [ACC_W-1:0] re;
    logic [ACC_W-1:0] im;
  } beam_exp_t;

  typedef struct {
    logic               chk;
    logic [ACC_W_S-1:0] re;
  } s_exp_t;

  beam_exp_t exp_q[$];
  int        err_q[$];
  s_exp_t    s_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      beam_exp_t e;
      s_exp_t    se;
      int        d;
      if (beam_valid) begin
        if (exp_q.size() == 0) check("beam_unexpected", 64'(beam_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("beam_cycle", 64'(cyc), 64'(e.due));
          check("beam_real", 64'(beam_real), 64'(e.re));
          check("beam_image", 64'(beam_image), 64'(e.im));
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
        e = exp_q.pop_front();
        check("beam_missing", 64'(beam_valid), 64'd1);
      end
      if (frame_err) begin
        if (err_q.size() == 0) check("err_unexpected", 64'(frame_err), 64'd0);
        else begin
          d = err_q.pop_front();
          check("err_cycle", 64'(cyc), 64'(d));
        end
      end else if (err_q.size() > 0 && cyc >= err_q[0]) begin
        d = err_q.pop_front();
        check("err_missing", 64'(frame_err), 64'd1);
      end
      if (beam_valid_s) begin
        if (s_q.size() == 0) check("beam_s_unexpected", 64'(beam_valid_s), 64'd0);
        else begin
          se = s_q.pop_front();
          if (se.chk) begin
            check("beam_s_real", 64'(beam_real_s), 64'(se.re));
            check("beam_s_image", 64'(beam_image_s), 64'd0);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [6:0] idx, input logic [DW-1:0] ar, input logic [DW-1:0] ai);
    ch_valid = 1'b1;
    ch_idx   = idx;
    ch_real  = ar;
    ch_image = ai;
    @(posedge clk); #1;
    ch_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    ch_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bad(input logic [6:0] idx);
    err_q.push_back(cyc + 3);
    send(idx, 16'h0001, 16'h0000);
  endtask

  typedef struct {
    logic [DW-1:0]      ar, ai, cr, ci;
    int                 max_gap;
    logic [ACC_W-1:0]   exp_re, exp_im;
    logic               chk_s;
    logic [ACC_W_S-1:0] exp_s;
  } vec_t;

  // Whole frame with one sample and one coefficient on every channel.
  task automatic run_frame(input vec_t v);
    for (int k = 1; k <= NUM_CH; k++) begin
      cr_tbl[k] = v.cr;
      ci_tbl[k] = v.ci;
    end
    for (int k = 1; k <= NUM_CH; k++) begin
      if (k == NUM_CH) begin
        exp_q.push_back('{cyc + 3, v.exp_re, v.exp_im});
        s_q.push_back('{v.chk_s, v.exp_s});
      end
      send(7'(k), v.ar, v.ai);
      if (k < NUM_CH && v.max_gap > 0) idle($urandom_range(0, v.max_gap));
    end
  endtask

  // Frame with random samples and coefficients, expected from a longint model.
  task automatic run_random_frame();
    logic [DW-1:0] ar [1:NUM_CH];
    logic [DW-1:0] ai [1:NUM_CH];
    longint sr, si;
    longint a_r, a_i, c_r, c_i;
    sr = 0;
    si = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      ar[k] = 16'($urandom_range(0, 65535));
      ai[k] = 16'($urandom_range(0, 65535));
      cr_tbl[k] = 16'($urandom_range(0, 65535));
      ci_tbl[k] = 16'($urandom_range(0, 65535));
      a_r = longint'($signed(ar[k]));
      a_i = longint'($signed(ai[k]));
      c_r = longint'($signed(cr_tbl[k]));
      c_i = longint'($signed(ci_tbl[k]));
      sr += a_r * c_r - a_i * c_i;
      si += a_r * c_i + a_i * c_r;
    end
    for (int k = 1; k <= NUM_CH; k++) begin
      if (k == NUM_CH) begin
        exp_q.push_back('{cyc + 3, ACC_W'(sr), ACC_W'(si)});
        s_q.push_back('{1'b0, '0});
      end
      send(7'(k), ar[k], ai[k]);
      if (k < NUM_CH) idle($urandom_range(0, 2));
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs [7];

  initial begin
    vecs[0] = '{16'h4000, 16'h0000, 16'h7FFF, 16'h0000, 0, 40'h05FFF40000, 40'h0, 1'b0, 34'h0};
    vecs[1] = '{16'h0000, 16'h4000, 16'h0000, 16'h4000, 0, 40'hFD00000000, 40'h0, 1'b0, 34'h0};
    vecs[2] = '{16'h0001, 16'h0000, 16'h0001, 16'h0000, 3, 40'h0000000030, 40'h0, 1'b0, 34'h0};
    vecs[3] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 0, 40'hFFFFFFFFD0, 40'h0, 1'b0, 34'h0};
    vecs[4] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 0, 40'h0, 40'h1800000000, 1'b0, 34'h0};
    vecs[5] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 2, 40'h17FFB80030, 40'hFFFFE80030, 1'b0, 34'h0};
    vecs[6] = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 0, 40'h0BFFD00030, 40'h0, 1'b1, EXP_S_MAX};

    for (int i = 0; i < 128; i++) begin
      cr_tbl[i] = '0;
      ci_tbl[i] = '0;
    end

    // reset state
    rst      = 1'b1;
    ch_valid = 1'b0;
    ch_idx   = 7'd37;
    ch_real  = '0;
    ch_image = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_beam_real", 64'(beam_real), 64'd0);
    check("rst_beam_image", 64'(beam_image), 64'd0);
    check("rst_beam_valid", 64'(beam_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("c_follows_idx", 64'(c), 64'd37);
    rst = 1'b0;
    idle(2);
    check("idle_beam_valid", 64'(beam_valid), 64'd0);

    // table of full frames, applied back-to-back
    for (int i = 0; i < 7; i++) run_frame(vecs[i]);
    idle(6);

    // skipped index 1,2,3,5, then a clean frame
    send(7'd1, 16'h0001, 16'h0);
    send(7'd2, 16'h0001, 16'h0);
    send(7'd3, 16'h0001, 16'h0);
    send_bad(7'd5);
    idle(5);
    run_frame(vecs[2]);
    idle(4);

    // out-of-range and out-of-frame indices
    send_bad(7'd0);
    send_bad(7'd3);
    send(7'd1, 16'h0001, 16'h0);
    send(7'd2, 16'h0001, 16'h0);
    send_bad(7'd49);
    idle(2);
    send(7'd1, 16'h0001, 16'h0);
    send(7'd2, 16'h0001, 16'h0);
    send_bad(7'd2);
    idle(3);

    // idx 1 mid-frame restarts the frame
    for (int k = 1; k <= 10; k++) send(7'(k), 16'h0123, 16'h0456);
    err_q.push_back(cyc + 3);
    run_frame(vecs[0]);
    idle(5);

    // reset mid-frame
    for (int k = 1; k <= 20; k++) send(7'(k), 16'h0001, 16'h0);
    rst = 1'b1;
    #1;
    check("midrst_beam_real", 64'(beam_real), 64'd0);
    check("midrst_beam_image", 64'(beam_image), 64'd0);
    check("midrst_beam_valid", 64'(beam_valid), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    run_frame(vecs[1]);

    // random frame against the arithmetic model
    run_random_frame();

    // drain
    for (int n = 0; n < 20; n++) begin
      if (exp_q.size() == 0 && err_q.size() == 0 && s_q.size() == 0) break;
      @(posedge clk); #1;
    end
    idle(3);
    check("beam_q_drained", 64'(exp_q.size()), 64'd0);
    check("err_q_drained", 64'(err_q.size()), 64'd0);
    check("beam_s_q_drained", 64'(s_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fangwei_beam_accum.md
FANGWEI_BEAM_ACCUM -- requirements
Module: fangwei_beam_accum

Interface
REQ-001 SHALL have parameter NUM_CH, default 48: number of array channels per azimuth frame.
REQ-002 SHALL have parameter DW, default 16: sample and coefficient width, signed Q1.15.
REQ-003 SHALL have parameter ACC_W, default 40: accumulator and beam output width.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst, input, 1: reset; asynchronous, active-high.
REQ-006 SHALL have port ch_valid, input, 1: channel sample present this cycle.
REQ-007 SHALL have port ch_idx, input, 7: channel number, 1..NUM_CH.
REQ-008 SHALL have ports ch_real and ch_image, input, DW each: channel sample.
REQ-009 SHALL have port c, output, 7: coefficient-selector index, driven combinationally equal to ch_idx.
REQ-010 SHALL have ports coef_real and coef_image, input, DW each: selector coefficient, valid one cycle after c.
REQ-011 SHALL have ports beam_real and beam_image, output, ACC_W each: summed beam result.
REQ-012 SHALL have port beam_valid, output, 1: one-cycle pulse qualifying the beam outputs.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse on sequence violation.

Function
REQ-014 SHALL register ch_real, ch_image, ch_idx and ch_valid once (stage S1) to align them with coef_real and coef_image.
REQ-015 SHALL compute the complex product (ar*cr - ai*ci) + j(ar*ci + ai*cr) with full 2*DW+1-bit signed precision and register the result (stage S2).
REQ-016 SHALL sign-extend each S2 product to ACC_W and add it into the accumulator (stage S3); when the S2 index is 1, the accumulator SHALL load the product instead of adding.
REQ-017 SHALL implement FSM IDLE -> ACCUM on an accepted idx 1; ACCUM -> DONE when idx NUM_CH has been accumulated; DONE -> IDLE unconditionally after 1 cycle.
REQ-018 SHALL hold beam_valid high during DONE, i.e., 3 cycles after the ch_valid cycle carrying idx NUM_CH; beam outputs SHALL hold their value until the next DONE.
REQ-019 SHALL require indices in a frame to be strictly sequential (prev+1); idle cycles (ch_valid low) between channels SHALL be allowed.
REQ-020 SHALL pulse frame_err, discard the partial sum and return to IDLE on idx 0, idx > NUM_CH, a skipped or repeated idx, or idx != 1 while IDLE.
REQ-021 SHALL treat idx 1 arriving mid-frame as frame_err plus the start of a new frame with that sample.
REQ-022 SHALL accept idx 1 of the next frame in the cycle immediately after idx NUM_CH, with no bubble.
REQ-023 SHALL wrap the accumulator on two's-complement overflow unless FANGWEI_BEAM_SAT_EN is defined.

Reset
REQ-024 SHALL clear, while rst is high, all pipeline registers, the accumulator, the FSM (to IDLE), beam_real, beam_image (to 0), beam_valid and frame_err (to 0).
REQ-025 SHALL discard any frame in flight when rst is asserted mid-frame, with no beam_valid or frame_err for it after release.

Configuration
REQ-026 SHALL, when FANGWEI_BEAM_SAT_EN is defined, clamp accumulator updates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; when it is undefined, the accumulator SHALL wrap.

Structure
REQ-027 SHALL take DW, NUM_CH, ACC_W defaults and the FSM state enumeration from shared package fangwei_pkg.
REQ-028 SHALL implement S2 in sub-module fangwei_cmult, a registered complex multiplier with latency 1.

Verification
REQ-029 SHALL cover: 48 channels back-to-back, samples 0x4000+j0, coef 0x7FFF+j0 -> one beam_valid 3 cycles after idx 48, beam_real 0x5FFF40000, beam_image 0.
REQ-030 SHALL cover: sample 0+j0x4000, coef 0+j0x4000 on all channels -> beam_real -48*0x10000000, beam_image 0.
REQ-031 SHALL cover: sequence 1,2,3,5 -> frame_err on the idx-5 cycle plus 3, no beam_valid; the following clean frame sums correctly.
REQ-032 SHALL cover: two frames back-to-back, first all +1 products, second all -1 products -> second beam is not polluted by the first.
REQ-033 SHALL cover: rst pulsed after idx 20 -> outputs 0 immediately; a following full frame yields the correct beam.
REQ-034 SHALL cover: ACC_W=34 with 0x7FFF*0x7FFF on all channels -> wraps without the macro and saturates to 0x1FFFFFFFF with FANGWEI_BEAM_SAT_EN defined.
